digital_loop_filter: RTL and testbench
======================================

Name: digital_loop_filter

Overview:
- Bang-bang PI loop filter for the ADPLL. It sits directly downstream of the UP/DN glitch filter and consumes its filtered UP/DN pulses.
- Decimates the ternary phase error over a fixed window, then updates a saturating integrator and produces the DCO control word.
- Runs a two-state gain schedule: high-gain acquisition (ACQ), then low-gain tracking (TRACK). Transitions are set by a window-based lock detector.

Parameters:
- CW, 10: DCO control word width (bits).
- WIN, 16: decimation window length in clk cycles; power of two, 4..256.
- KP_ACQ, 3: proportional left shift in ACQ.
- KI_ACQ, 2: integral left shift in ACQ.
- KP_TRK, 1: proportional left shift in TRACK.
- KI_TRK, 0: integral left shift in TRACK.
- LOCK_TOL, 2: maximum |window sum| that counts as an in-lock window.
- LOCK_WINS, 4: number of consecutive in-lock windows needed to enter TRACK.
- UNLOCK_TOL, 8: a |window sum| above this in TRACK drops back to ACQ.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset, sampled on the rising edge of clk.
- UP_in  in  1  filtered UP from the glitch filter.
- DN_in  in  1  filtered DN from the glitch filter.
- freeze  in  1  hold the loop: window counting and updates are paused.
- dco_ctrl  out  CW  DCO control word, unsigned.
- ctrl_valid  out  1  one-cycle pulse, high in the cycle dco_ctrl takes a new value.
- locked  out  1  high while in TRACK.

Behaviour:
- Reset, synchronous: on a clk edge with reset=1, all of the following load together.
  - integ and dco_ctrl = CENTER = 2^(CW-1), i.e. 512 at default.
  - Window counter = 0, window sum = 0, lock counter = 0.
  - State = ACQ; ctrl_valid = 0; locked = 0.
  - Reset asserted mid-window discards the partial sum.
- Per-cycle error e:
  - UP_in & !DN_in gives +1.
  - DN_in & !UP_in gives -1.
  - Both high or both low gives 0.
- Window accumulation:
  - When freeze=0, sum += e and cnt increments, wrapping WIN-1 to 0.
  - sum is signed, clog2(WIN)+2 bits, and never overflows because |sum| <= WIN.
- Window end, on a cycle with cnt==WIN-1 and freeze=0:
  - S = sum + e for the current cycle, so the current sample is included.
  - Select shifts (KP, KI) from the current state.
  - integ_n = clamp(integ + (S <<< KI), 0, 2^CW-1).
  - dco_ctrl <= clamp(integ_n + (S <<< KP), 0, 2^CW-1).
  - integ <= integ_n; ctrl_valid <= 1 for exactly one cycle.
  - sum <= 0; cnt <= 0.
- Latency: dco_ctrl and ctrl_valid change on the edge that ends sample WIN, i.e. they are visible in the cycle after the last window sample.
- Arithmetic: all sums and shifts are computed signed at CW+clog2(WIN)+4 bits before the clamp, so no intermediate result wraps.
- Lock FSM, evaluated only at window end:
  - ACQ: if |S| <= LOCK_TOL then lockcnt++, else lockcnt = 0.
  - ACQ: when lockcnt reaches LOCK_WINS, go to TRACK, set locked=1, clear lockcnt. This window's update still uses ACQ gains; TRACK gains apply from the next window.
  - TRACK: if |S| > UNLOCK_TOL, go to ACQ, set locked=0, clear lockcnt. This window's update uses TRACK gains. Otherwise stay in TRACK.
  - lockcnt saturates at LOCK_WINS.
- freeze=1:
  - cnt, sum, integ, dco_ctrl, state and lockcnt all hold; ctrl_valid=0.
  - freeze on a window-end cycle suppresses that update; the window completes on the first unfrozen cycle that has cnt==WIN-1.
- The integrator clamp holds at its bound, with no wrap.
- A zero-error window still pulses ctrl_valid and re-evaluates the lock conditions.

Decomposition:
- adpll_pkg holds:
  - a loop_state_t enum {ACQ, TRACK};
  - the function clog2;
  - a function sat_u(value, CW) that clamps a wide signed value to the unsigned CW range;
  - the constant CENTER.
- One sub-module, loop_err_accum: the ternary error decode, window counter and sum. It outputs win_end and S. The top level holds the integrator, the output register and the FSM.

Test Plan:
- Reset, then UP=DN=0 for 16 cycles -> dco_ctrl=512, ctrl_valid pulses at cycle 17, locked=0.
- UP=1, DN=0 for 16 cycles from reset -> S=16, integ=576, dco_ctrl=704, single ctrl_valid pulse.
- Hold UP=1 continuously -> integ increments by 64 per window and saturates at 1023; dco_ctrl stays 1023 with no wrap.
- UP=DN=1 for a window, then alternate UP/DN every cycle for 4 windows (S=0) -> locked rises at the 4th window end. In the next window 16 UP cycles give a TRACK step: integ +16, dco_ctrl = integ + 32. Since 16 > UNLOCK_TOL, that window also returns the block to ACQ with locked=0.
- Assert freeze for 10 cycles across a window end -> no ctrl_valid and all state held; the update occurs when the window completes after freeze drops.
- Assert reset mid-window after 8 UP cycles -> dco_ctrl=512, locked=0, next window starts from cnt=0, sum=0.

Source files
------------

// File: rtl/adpll_pkg.sv
// Shared types and helpers for the ADPLL loop filter.
package adpll_pkg;

    typedef enum logic {
        ACQ   = 1'b0,
        TRACK = 1'b1
    } loop_state_t;

    localparam int unsigned CW_DEFAULT = 10;
    localparam int unsigned CENTER     = 2 ** (CW_DEFAULT - 1);

    // Width of the generic signed operand taken by sat_u.
    localparam int unsigned SAT_W = 64;

    // Ceiling log2, usable in constant expressions.
    function automatic int unsigned clog2(input int unsigned v);
        int unsigned r;
        r = 0;
        while ((64'd1 << r) < 64'(v)) begin
            r = r + 1;
        end
        return r;
    endfunction

    // Clamp a wide signed value into the unsigned range [0, 2^cw-1].
    function automatic logic [31:0] sat_u(input logic signed [SAT_W-1:0] value,
                                          input int unsigned            cw);
        logic signed [SAT_W-1:0] hi;
        hi = $signed((64'd1 << cw) - 64'd1);
        if (value < 0) begin
            return 32'd0;
        end
        if (value > hi) begin
            return hi[31:0];
        end
        return value[31:0];
    endfunction

endpackage

// File: rtl/loop_err_accum.sv
// Ternary UP/DN error decode with windowed accumulation.
module loop_err_accum
    import adpll_pkg::*;
#(
    parameter int unsigned WIN = 16
) (
    input  logic                                 clk,
    input  logic                                 reset,
    input  logic                                 up_in,
    input  logic                                 dn_in,
    input  logic                                 freeze,
    output logic                                 win_end_c,
    output logic signed [clog2(WIN)+2-1:0]       win_sum_c
);

    localparam int unsigned CNTW = clog2(WIN);
    localparam int unsigned SW   = clog2(WIN) + 2;

    logic [CNTW-1:0]         cnt_q, cnt_d;
    logic signed [SW-1:0]    sum_q, sum_d;
    logic signed [SW-1:0]    err;

    // Error decode, window-end detect and next counter/sum.
    always_comb begin
        err   = '0;
        cnt_d = cnt_q;
        sum_d = sum_q;
        case ({up_in, dn_in})
            2'b10:   err = SW'(1);
            2'b01:   err = '1;
            default: err = '0;
        endcase
        win_sum_c = sum_q + err;
        win_end_c = !freeze && (cnt_q == CNTW'(WIN - 1));
        if (!freeze) begin
            if (win_end_c) begin
                cnt_d = '0;
                sum_d = '0;
            end else begin
                cnt_d = cnt_q + CNTW'(1);
                sum_d = win_sum_c;
            end
        end
    end

    // Counter and partial-sum registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
            sum_q <= '0;
        end else begin
            cnt_q <= cnt_d;
            sum_q <= sum_d;
        end
    end

endmodule

// File: rtl/digital_loop_filter.sv
// Bang-bang PI loop filter with ACQ/TRACK gain schedule.
module digital_loop_filter
    import adpll_pkg::*;
#(
    parameter int unsigned CW         = 10,
    parameter int unsigned WIN        = 16,
    parameter int unsigned KP_ACQ     = 3,
    parameter int unsigned KI_ACQ     = 2,
    parameter int unsigned KP_TRK     = 1,
    parameter int unsigned KI_TRK     = 0,
    parameter int unsigned LOCK_TOL   = 2,
    parameter int unsigned LOCK_WINS  = 4,
    parameter int unsigned UNLOCK_TOL = 8
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          UP_in,
    input  logic          DN_in,
    input  logic          freeze,
    output logic [CW-1:0] dco_ctrl,
    output logic          ctrl_valid,
    output logic          locked
);

    localparam int unsigned SW  = clog2(WIN) + 2;
    localparam int unsigned AW  = CW + clog2(WIN) + 4;
    localparam int unsigned LCW = clog2(LOCK_WINS + 1);
    localparam logic [CW-1:0] MID = CW'(1) << (CW - 1);

    logic                  win_end_c;
    logic signed [SW-1:0]  win_sum_c;

    logic [CW-1:0]   integ_q, integ_d;
    logic [CW-1:0]   dco_q, dco_d;
    logic            valid_q, valid_d;
    loop_state_t     state_q, state_d;
    logic [LCW-1:0]  lockcnt_q, lockcnt_d;

    logic signed [AW-1:0] s_w;
    logic [AW-1:0]        s_abs;
    logic [CW-1:0]        integ_n;
    logic [CW-1:0]        dco_n;
    logic [LCW-1:0]       lock_inc;
    int unsigned          kp;
    int unsigned          ki;

    loop_err_accum #(
        .WIN (WIN)
    ) u_accum (
        .clk       (clk),
        .reset     (reset),
        .up_in     (UP_in),
        .dn_in     (DN_in),
        .freeze    (freeze),
        .win_end_c (win_end_c),
        .win_sum_c (win_sum_c)
    );

    // PI update and lock detector, both evaluated only at window end.
    always_comb begin
        integ_d   = integ_q;
        dco_d     = dco_q;
        valid_d   = 1'b0;
        state_d   = state_q;
        lockcnt_d = lockcnt_q;
        kp        = (state_q == TRACK) ? KP_TRK : KP_ACQ;
        ki        = (state_q == TRACK) ? KI_TRK : KI_ACQ;
        s_w       = AW'(win_sum_c);
        s_abs     = $unsigned(s_w[AW-1] ? -s_w : s_w);
        integ_n   = CW'(sat_u(SAT_W'(AW'($signed({1'b0, integ_q})) + (s_w <<< ki)), CW));
        dco_n     = CW'(sat_u(SAT_W'(AW'($signed({1'b0, integ_n})) + (s_w <<< kp)), CW));
        lock_inc  = (lockcnt_q == LCW'(LOCK_WINS)) ? lockcnt_q : lockcnt_q + LCW'(1);

        if (win_end_c) begin
            integ_d = integ_n;
            dco_d   = dco_n;
            valid_d = 1'b1;
            case (state_q)
                ACQ: begin
                    if (s_abs <= AW'(LOCK_TOL)) begin
                        if (lock_inc >= LCW'(LOCK_WINS)) begin
                            state_d   = TRACK;
                            lockcnt_d = '0;
                        end else begin
                            lockcnt_d = lock_inc;
                        end
                    end else begin
                        lockcnt_d = '0;
                    end
                end
                TRACK: begin
                    if (s_abs > AW'(UNLOCK_TOL)) begin
                        state_d   = ACQ;
                        lockcnt_d = '0;
                    end
                end
                default: begin
                    state_d   = ACQ;
                    lockcnt_d = '0;
                end
            endcase
        end
    end

    // Loop state registers; reset recentres the DCO word.
    always_ff @(posedge clk) begin
        if (reset) begin
            integ_q   <= MID;
            dco_q     <= MID;
            valid_q   <= 1'b0;
            state_q   <= ACQ;
            lockcnt_q <= '0;
        end else begin
            integ_q   <= integ_d;
            dco_q     <= dco_d;
            valid_q   <= valid_d;
            state_q   <= state_d;
            lockcnt_q <= lockcnt_d;
        end
    end

    assign dco_ctrl   = dco_q;
    assign ctrl_valid = valid_q;
    assign locked     = (state_q == TRACK);

endmodule

// File: tb/tb_digital_loop_filter.sv
// Directed bench for digital_loop_filter at default parameters.
module tb_digital_loop_filter;

    logic       clk;
    logic       reset;
    logic       UP_in;
    logic       DN_in;
    logic       freeze;
    logic [9:0] dco_ctrl;
    logic       ctrl_valid;
    logic       locked;

    int n_checks = 0;
    int n_errors = 0;
    logic alt_ph = 1'b0;

    digital_loop_filter dut (
        .clk        (clk),
        .reset      (reset),
        .UP_in      (UP_in),
        .DN_in      (DN_in),
        .freeze     (freeze),
        .dco_ctrl   (dco_ctrl),
        .ctrl_valid (ctrl_valid),
        .locked     (locked)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // One clock: apply inputs, take the edge, settle past it.
    task automatic tick(input logic u, input logic d, input logic f, input logic r);
        UP_in  = u;
        DN_in  = d;
        freeze = f;
        reset  = r;
        @(posedge clk);
        #1;
    endtask

    // mode: 0 idle, 1 UP, 2 DN, 3 both, 4 alternate UP/DN.
    task automatic run(input int mode, input int n, output int pulses);
        pulses = 0;
        for (int i = 0; i < n; i++) begin
            case (mode)
                1: tick(1'b1, 1'b0, 1'b0, 1'b0);
                2: tick(1'b0, 1'b1, 1'b0, 1'b0);
                3: tick(1'b1, 1'b1, 1'b0, 1'b0);
                4: begin
                    tick(alt_ph, !alt_ph, 1'b0, 1'b0);
                    alt_ph = !alt_ph;
                end
                default: tick(1'b0, 1'b0, 1'b0, 1'b0);
            endcase
            pulses += int'(ctrl_valid);
        end
    endtask

    // Full 16-cycle window: no pulse early, a pulse right after the last sample.
    task automatic window(input int mode, input string tag);
        int p;
        run(mode, 15, p);
        check({tag, " early valid"}, 32'(p), 32'd0);
        run(mode, 1, p);
        check({tag, " valid"}, 32'(ctrl_valid), 32'd1);
    endtask

    initial begin
        int p;
        tick(1'b0, 1'b0, 1'b0, 1'b1);
        tick(1'b0, 1'b0, 1'b0, 1'b1);
        check("reset dco", 32'(dco_ctrl), 32'd512);
        check("reset valid", 32'(ctrl_valid), 32'd0);
        check("reset locked", 32'(locked), 32'd0);

        // Zero-error window still pulses, output stays centred.
        window(0, "idle");
        check("idle dco", 32'(dco_ctrl), 32'd512);
        check("idle locked", 32'(locked), 32'd0);
        tick(1'b0, 1'b0, 1'b0, 1'b0);
        check("valid one-shot", 32'(ctrl_valid), 32'd0);

        // ACQ gains from reset: S=16 -> integ 576, dco 704.
        tick(1'b0, 1'b0, 1'b0, 1'b1);
        window(1, "up1");
        check("up1 dco", 32'(dco_ctrl), 32'd704);
        window(1, "up2");
        check("up2 dco", 32'(dco_ctrl), 32'd768);
        for (int k = 3; k <= 7; k++) window(1, "upk");
        check("up7 dco clamp", 32'(dco_ctrl), 32'd1023);
        for (int k = 8; k <= 10; k++) window(1, "upsat");
        check("up10 dco held", 32'(dco_ctrl), 32'd1023);
        // Integrator pinned at 1023: 1023-64=959, dco 959-128=831.
        window(2, "dn after sat");
        check("dn after sat dco", 32'(dco_ctrl), 32'd831);
        check("sat locked", 32'(locked), 32'd0);

        // Lock acquisition: both-high window plus alternating windows.
        tick(1'b0, 1'b0, 1'b0, 1'b1);
        alt_ph = 1'b0;
        window(3, "both");
        check("both dco", 32'(dco_ctrl), 32'd512);
        check("both locked", 32'(locked), 32'd0);
        window(4, "alt1");
        check("alt1 locked", 32'(locked), 32'd0);
        window(4, "alt2");
        check("alt2 locked", 32'(locked), 32'd0);
        window(4, "alt3");
        check("alt3 locked", 32'(locked), 32'd1);
        check("alt3 dco", 32'(dco_ctrl), 32'd512);
        window(4, "alt4");
        check("alt4 locked", 32'(locked), 32'd1);
        check("alt4 dco", 32'(dco_ctrl), 32'd512);
        // TRACK step: integ 528, dco 560, then unlock.
        window(1, "trk up");
        check("trk up dco", 32'(dco_ctrl), 32'd560);
        check("trk up locked", 32'(locked), 32'd0);
        // Back on ACQ gains: integ 592, dco 720.
        window(1, "reacq up");
        check("reacq dco", 32'(dco_ctrl), 32'd720);

        // Freeze across the window end.
        tick(1'b0, 1'b0, 1'b0, 1'b1);
        run(1, 15, p);
        check("pre-freeze valid", 32'(p), 32'd0);
        p = 0;
        for (int i = 0; i < 10; i++) begin
            tick(1'b1, 1'b0, 1'b1, 1'b0);
            p += int'(ctrl_valid);
        end
        check("frozen valid", 32'(p), 32'd0);
        check("frozen dco", 32'(dco_ctrl), 32'd512);
        tick(1'b1, 1'b0, 1'b0, 1'b0);
        check("unfreeze valid", 32'(ctrl_valid), 32'd1);
        check("unfreeze dco", 32'(dco_ctrl), 32'd704);

        // Reset mid-window discards the partial sum.
        run(1, 8, p);
        tick(1'b1, 1'b0, 1'b0, 1'b1);
        check("midrst dco", 32'(dco_ctrl), 32'd512);
        check("midrst valid", 32'(ctrl_valid), 32'd0);
        check("midrst locked", 32'(locked), 32'd0);
        window(2, "dn after rst");
        check("dn after rst dco", 32'(dco_ctrl), 32'd320);

        // Reset clears the lock counter.
        tick(1'b0, 1'b0, 1'b0, 1'b1);
        for (int k = 0; k < 3; k++) window(0, "pre-rst lock");
        tick(1'b0, 1'b0, 1'b0, 1'b1);
        for (int k = 0; k < 3; k++) window(0, "post-rst lock");
        check("lockcnt cleared", 32'(locked), 32'd0);
        window(0, "fourth lock");
        check("fourth locked", 32'(locked), 32'd1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    // Hard bound on simulated time.
    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule
